oled_cmd_sequencer: RTL and testbench
=====================================

// Module: oled_cmd_sequencer
// PURPOSE
//  Upstream feeder for the OLED SPI byte transmitter. After reset it pulses the panel reset pin, streams a fixed
//  25-byte SSD1306 init list, then drains a host byte FIFO (byte + D/C flag) one byte per SPI transaction.
//  Paces every byte with the transmitter's spi_send / spi_send_done handshake.
// PARAMETERS
//  RST_LOW_CYC   1000  clk cycles oled_res_n is held low after reset
//  RST_WAIT_CYC  1000  clk cycles waited after oled_res_n rises, before the first init byte
//  FIFO_DEPTH    16    host FIFO entries; power of two, >=2
//  AW            4     log2(FIFO_DEPTH)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  wr_en         in   1   host write strobe, one entry per cycle
//  wr_data       in   8   host byte
//  wr_dc         in   1   host D/C flag (0 = command, 1 = data)
//  full          out  1   FIFO holds FIFO_DEPTH entries
//  ovf           out  1   one-cycle pulse: wr_en seen while full, byte dropped
//  init_done     out  1   init list complete; stays high until rst
//  busy          out  1   a byte is in flight, or FIFO not empty, or init not done
//  spi_send      out  1   request to transmitter, level
//  spi_data_out  out  8   byte to transmit
//  spi_dc        out  1   D/C for the byte in flight (to transmitter dc_in)
//  spi_send_done in   1   transmitter completion, high for many clk cycles
//  oled_res_n    out  1   panel reset pin, active-low
// BEHAVIOUR
//  Reset values (rst high at a clk edge):
//   - oled_res_n=0, spi_send=0, spi_data_out=0, spi_dc=0, init_done=0, full=0, ovf=0, busy=1.
//   - FIFO pointers and count cleared; state=RES_LOW; timer=0.
//   - rst mid-transfer aborts immediately. A pending spi_send_done is ignored via WAIT_CLR semantics: after reset
//     nothing is issued until init starts, which is much longer than one transmitter period.
//  FSM:
//   - RES_LOW   : count RST_LOW_CYC cycles -> RES_WAIT; oled_res_n=1.
//   - RES_WAIT  : count RST_WAIT_CYC cycles -> LOAD.
//   - LOAD      : if init index<25, byte=ROM[idx] and dc=0; else if FIFO not empty, pop head into spi_data_out/spi_dc;
//                 else stay (IDLE behaviour). On load: spi_send=1 -> WAIT_DONE.
//   - WAIT_DONE : hold spi_send, spi_data_out, spi_dc stable until spi_send_done=1; then spi_send=0 -> WAIT_CLR.
//   - WAIT_CLR  : wait for spi_send_done=0, then -> LOAD. Guarantees exactly one byte per done pulse.
//  init_done: set in the cycle idx increments to 25, i.e. on leaving WAIT_CLR after the 25th byte.
//  Init ROM, in order, all dc=0:
//   AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF
//  FIFO:
//   - Writes are accepted in every state, including reset-pulse and init.
//   - Write accepted iff wr_en && !full (full sampled before the edge); no write-through on a full FIFO,
//     even with a simultaneous pop.
//   - Simultaneous write and pop when not full: count unchanged, both pointers advance.
//   - Pointers are AW bits and wrap naturally; count is AW+1 bits.
//   - full = (count==FIFO_DEPTH); registered.
//  ovf: one-cycle pulse per rejected write; never stalls the sequencer.
//  busy: = !init_done | (state!=LOAD) | (count!=0).
//  Order guarantee: host bytes are never sent before the final init byte, and leave the FIFO in write order.
// TESTING
//  1. rst 1 cycle, then done-responder (10-cycle latency, 5-cycle pulse) -> res_n low 1000 cyc, high, +1000 cyc,
//     then AE..AF in order with dc=0; init_done after the 25th done.
//  2. Write A5/dc=1 and 3C/dc=0 during RES_LOW -> sent after AF, in order, with spi_dc 1 then 0.
//  3. Responder holds done high 40 cycles -> exactly one byte per pulse; spi_send drops within 1 cycle of done.
//  4. 17 writes while stalled (done never returns) with DEPTH=16 -> full=1 after 16th, ovf pulse on 17th;
//     16 bytes are later sent.
//  5. Full FIFO plus wr_en in the pop cycle -> write rejected, ovf=1, count 15.
//  6. rst asserted in WAIT_DONE -> next cycle spi_send=0, oled_res_n=0, FIFO empty; sequence restarts from AE.

Source files
------------

// File: rtl/oled_cmd_sequencer.sv
// OLED command sequencer: pulses the panel reset pin, streams the SSD1306 init list, then
// drains a host byte FIFO, one byte per transmitter send/done handshake.
module oled_cmd_sequencer #(
   parameter int unsigned RST_LOW_CYC  = 1000,
   parameter int unsigned RST_WAIT_CYC = 1000,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned AW           = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       wr_dc,
   output logic       full,
   output logic       ovf,
   output logic       init_done,
   output logic       busy,
   output logic       spi_send,
   output logic [7:0] spi_data_out,
   output logic       spi_dc,
   input  logic       spi_send_done,
   output logic       oled_res_n
);

   localparam int unsigned CW        = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
   localparam logic [4:0] InitLen    = 5'd25;

   typedef enum logic [2:0] {
      StResLow,
      StResWait,
      StLoad,
      StWaitDone,
      StWaitClr
   } state_e;

   state_e        state_q;
   logic [31:0]   timer_q;
   logic [4:0]    init_idx_q;

   // FIFO storage: {dc, byte}
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          push;
   logic          pop;

   function automatic logic [7:0] init_rom(input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = 8'hAE;
         5'd1:    b = 8'hD5;
         5'd2:    b = 8'h80;
         5'd3:    b = 8'hA8;
         5'd4:    b = 8'h3F;
         5'd5:    b = 8'hD3;
         5'd6:    b = 8'h00;
         5'd7:    b = 8'h40;
         5'd8:    b = 8'h8D;
         5'd9:    b = 8'h14;
         5'd10:   b = 8'h20;
         5'd11:   b = 8'h00;
         5'd12:   b = 8'hA1;
         5'd13:   b = 8'hC8;
         5'd14:   b = 8'hDA;
         5'd15:   b = 8'h12;
         5'd16:   b = 8'h81;
         5'd17:   b = 8'hCF;
         5'd18:   b = 8'hD9;
         5'd19:   b = 8'hF1;
         5'd20:   b = 8'hDB;
         5'd21:   b = 8'h40;
         5'd22:   b = 8'hA4;
         5'd23:   b = 8'hA6;
         5'd24:   b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Full is sampled before the edge, so a pop never makes room for a same-cycle write.
   assign push = wr_en & ~full;
   // Host bytes only leave once the whole init list has gone out.
   assign pop  = (state_q == StLoad) & (init_idx_q == InitLen) & (count_q != '0);

   // Next occupancy from push/pop combination
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write port (no reset needed; validity tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {wr_dc, wr_data};
      end
   end

   // FIFO pointers, occupancy, full flag and overflow pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         full    <= (count_d == FullCnt);
         ovf     <= wr_en & full;
      end
   end

   // Sequencer FSM with registered panel reset and transmitter outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StResLow;
         timer_q      <= '0;
         init_idx_q   <= '0;
         init_done    <= 1'b0;
         oled_res_n   <= 1'b0;
         spi_send     <= 1'b0;
         spi_data_out <= 8'h00;
         spi_dc       <= 1'b0;
      end else begin
         case (state_q)
            StResLow: begin
               if (timer_q == RST_LOW_CYC - 32'd1) begin
                  timer_q    <= '0;
                  oled_res_n <= 1'b1;
                  state_q    <= StResWait;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            StResWait: begin
               if (timer_q == RST_WAIT_CYC - 32'd1) begin
                  timer_q <= '0;
                  state_q <= StLoad;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            StLoad: begin
               if (init_idx_q < InitLen) begin
                  spi_data_out <= init_rom(init_idx_q);
                  spi_dc       <= 1'b0;
                  spi_send     <= 1'b1;
                  state_q      <= StWaitDone;
               end else if (count_q != '0) begin
                  {spi_dc, spi_data_out} <= mem[rd_ptr_q];
                  spi_send               <= 1'b1;
                  state_q                <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (spi_send_done) begin
                  spi_send <= 1'b0;
                  state_q  <= StWaitClr;
               end
            end
            StWaitClr: begin
               // Wait for done to fall so a long done pulse releases only one byte.
               if (!spi_send_done) begin
                  state_q <= StLoad;
                  if (init_idx_q < InitLen) begin
                     init_idx_q <= init_idx_q + 5'd1;
                     if (init_idx_q == InitLen - 5'd1) begin
                        init_done <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= StResLow;
         endcase
      end
   end

   assign busy = ~init_done | (state_q != StLoad) | (count_q != '0);

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Scoreboard bench for oled_cmd_sequencer: expected bytes queued at stimulus time, a monitor
// pops and compares on every new spi_send, and a done-responder models the SPI transmitter.
module tb_oled_cmd_sequencer;

   localparam int RST_LOW  = 1000;
   localparam int RST_WAIT = 1000;
   localparam logic [7:0] INIT_ROM [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1,
      8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_dc = 1'b0;
   logic       spi_send_done = 1'b0;
   logic       full, ovf, init_done, busy, spi_send, spi_dc, oled_res_n;
   logic [7:0] spi_data_out;

   oled_cmd_sequencer #(
      .RST_LOW_CYC (RST_LOW),
      .RST_WAIT_CYC(RST_WAIT),
      .FIFO_DEPTH  (16),
      .AW          (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .wr_dc        (wr_dc),
      .full         (full),
      .ovf          (ovf),
      .init_done    (init_done),
      .busy         (busy),
      .spi_send     (spi_send),
      .spi_data_out (spi_data_out),
      .spi_dc       (spi_dc),
      .spi_send_done(spi_send_done),
      .oled_res_n   (oled_res_n)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] exp_q[$];
   int         mon_sent = 0;
   logic       prev_send = 1'b0;
   logic [8:0] prev_byte = 9'h0;
   int         resp_lat = 10;
   int         resp_pulse = 5;
   bit         resp_en = 1'b1;
   int         r_phase = 0;
   int         r_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: each new request must match the scoreboard head and stay stable while held.
   always @(negedge clk) begin
      if (spi_send === 1'b1 && !prev_send) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h, expected none", {spi_dc, spi_data_out});
         end else begin
            check("byte_order", 32'({spi_dc, spi_data_out}), 32'(exp_q.pop_front()));
         end
         check("init_done_at_send", 32'(init_done), 32'(mon_sent >= 25));
         mon_sent++;
      end else if (spi_send === 1'b1 && prev_send) begin
         check("hold_stable", 32'({spi_dc, spi_data_out}), 32'(prev_byte));
      end
      prev_send = (spi_send === 1'b1);
      prev_byte = {spi_dc, spi_data_out};
   end

   // Transmitter model: latency, then a done pulse; send must drop and stay low during it.
   always @(negedge clk) begin
      if (rst) begin
         spi_send_done = 1'b0;
         r_phase = 0;
      end else begin
         case (r_phase)
            0: if (spi_send === 1'b1 && resp_en) begin
               r_cnt = resp_lat;
               r_phase = 1;
            end
            1: begin
               r_cnt--;
               if (r_cnt <= 0) begin
                  spi_send_done = 1'b1;
                  r_cnt = resp_pulse;
                  r_phase = 2;
               end
            end
            default: begin
               check("send_low_during_done", 32'(spi_send), 32'd0);
               r_cnt--;
               if (r_cnt <= 0) begin
                  spi_send_done = 1'b0;
                  r_phase = 0;
               end
            end
         endcase
      end
   end

   task automatic push_write(input logic [7:0] d, input logic dc);
      wr_data = d;
      wr_dc   = dc;
      wr_en   = 1'b1;
      exp_q.push_back({dc, d});
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      check("idle_after_drain", 32'(busy), 32'd0);
   endtask

   task automatic load_rom();
      exp_q.delete();
      for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, INIT_ROM[i]});
      mon_sent = 0;
   endtask

   task automatic wait_send(input string name);
      int k = 0;
      while (spi_send !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(spi_send), 32'd1);
   endtask

   initial begin
      int n_low;
      int n_high;
      int k;

      // Reset for one cycle and check reset values
      load_rom();
      @(negedge clk);
      rst = 1'b0;
      check("rst_res_n", 32'(oled_res_n), 32'd0);
      check("rst_send", 32'(spi_send), 32'd0);
      check("rst_data", 32'(spi_data_out), 32'd0);
      check("rst_dc", 32'(spi_dc), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);

      // Panel reset pulse width; host bytes written during it go out after the init list
      n_low = 1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         wr_en = 1'b0;
         if (oled_res_n === 1'b1) break;
         n_low++;
         if (n_low >= 10 && n_low < 18) begin
            wr_data = (n_low == 10) ? 8'hA5 : (n_low == 11) ? 8'h3C : 8'($urandom);
            wr_dc   = (n_low == 10) ? 1'b1 : (n_low == 11) ? 1'b0 : 1'($urandom);
            wr_en   = 1'b1;
            exp_q.push_back({wr_dc, wr_data});
         end
      end
      wr_en = 1'b0;
      check("res_low_cycles", 32'(n_low), 32'(RST_LOW));

      // Wait period plus the single load cycle before the first request
      n_high = 1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (spi_send === 1'b1) break;
         n_high++;
      end
      check("res_wait_cycles", 32'(n_high), 32'(RST_WAIT + 1));
      check("res_n_high", 32'(oled_res_n), 32'd1);
      drain("drain_init", 6000);
      check("init_done_set", 32'(init_done), 32'd1);

      // Long done pulses: one byte per pulse
      resp_pulse = 40;
      for (int i = 0; i < 4; i++) push_write(8'($urandom), 1'($urandom));
      drain("drain_long_pulse", 3000);
      resp_pulse = 5;

      // Stall the transmitter and overfill the FIFO
      resp_en = 1'b0;
      push_write(8'($urandom), 1'($urandom));
      wait_send("stall_send");
      for (int i = 0; i < 17; i++) begin
         wr_data = 8'($urandom);
         wr_dc   = 1'($urandom);
         wr_en   = 1'b1;
         if (i < 16) exp_q.push_back({wr_dc, wr_data});
         @(negedge clk);
         check("full_after_write", 32'(full), 32'(i >= 15));
         check("ovf_after_write", 32'(ovf), 32'(i == 16));
      end
      wr_en = 1'b0;
      @(negedge clk);
      check("ovf_single_pulse", 32'(ovf), 32'd0);
      check("full_held", 32'(full), 32'd1);

      // Release: keep writing while full, including the pop cycle; all are rejected
      resp_en = 1'b1;
      for (k = 0; k < 300; k++) begin
         wr_data = 8'($urandom);
         wr_dc   = 1'($urandom);
         wr_en   = 1'b1;
         @(negedge clk);
         check("ovf_while_full", 32'(ovf), 32'd1);
         if (full !== 1'b1) break;
      end
      wr_en = 1'b0;
      check("full_cleared_by_pop", 32'(full), 32'd0);
      push_write(8'($urandom), 1'($urandom));
      check("refill_to_16", 32'(full), 32'd1);
      drain("drain_full", 4000);

      // Randomized writes and transmitter timing
      for (int c = 0; c < 800; c++) begin
         if (c % 50 == 0) begin
            resp_lat   = $urandom_range(1, 12);
            resp_pulse = $urandom_range(1, 40);
         end
         if ($urandom_range(0, 3) == 0 && full === 1'b0) begin
            wr_data = 8'($urandom);
            wr_dc   = 1'($urandom);
            wr_en   = 1'b1;
            exp_q.push_back({wr_dc, wr_data});
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         check("ovf_random", 32'(ovf), 32'd0);
      end
      wr_en = 1'b0;
      drain("drain_random", 20000);

      // Reset while a byte is in flight: stale FIFO bytes must never appear
      resp_lat   = 10;
      resp_pulse = 5;
      resp_en    = 1'b0;
      for (int i = 0; i < 3; i++) push_write(8'($urandom), 1'($urandom));
      wait_send("send_before_rst");
      k = 0;
      while (exp_q.size() != 2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load_rom();
      check("mid_rst_send", 32'(spi_send), 32'd0);
      check("mid_rst_res_n", 32'(oled_res_n), 32'd0);
      check("mid_rst_full", 32'(full), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd1);
      check("mid_rst_init_done", 32'(init_done), 32'd0);
      resp_en = 1'b1;
      drain("drain_after_rst", 8000);
      repeat (50) @(negedge clk);
      check("init_done_after_rst", 32'(init_done), 32'd1);
      check("no_extra_bytes", 32'(spi_send), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
